// File: rtl/pic_pkg.sv
// +----------------------------------------------------------------------+
// | pic_pkg : shared types for the nested interrupt controller           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package pic_pkg;

  // Storage widths cover the largest legal configuration (64 channels).
  localparam int MAX_ID_W   = 6;
  localparam int MAX_PRIO_W = 8;

  typedef logic [MAX_ID_W-1:0]   int_id_t;
  typedef logic [MAX_PRIO_W-1:0] prio_t;

  typedef struct packed {
    logic  en;
    logic  edge_mode;
    prio_t prio;
  } ch_cfg_t;

  typedef struct packed {
    int_id_t id;
    prio_t   prio;
  } stk_entry_t;

  function automatic logic prio_above(input prio_t cand, input prio_t level);
    return cand > level;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pic_prio_arbiter.sv
// +----------------------------------------------------------------------+
// | pic_prio_arbiter : picks the highest-priority eligible channel,      |
// | ties resolved toward the highest ID.            Rev 1.0              |
// +----------------------------------------------------------------------+
`default_nettype none

module pic_prio_arbiter
  import pic_pkg::*;
#(
  parameter int NUM_CH = 16
) (
  input  logic [NUM_CH-1:0] eligible,
  input  prio_t             ch_prio [NUM_CH],
  output logic              win_valid,
  output int_id_t           win_id,
  output prio_t             win_prio
);

  // Scanning upward with >= lets a later (higher) ID take over on equal priority.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    win_prio  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (eligible[i] && (!win_valid || ch_prio[i] >= win_prio)) begin
        win_valid = 1'b1;
        win_id    = int_id_t'(i);
        win_prio  = ch_prio[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/nested_interrupt_controller.sv
// +----------------------------------------------------------------------+
// | nested_interrupt_controller : per-channel config, edge/level pend,   |
// | priority offer to the CPU and a preemption nest stack.   Rev 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module nested_interrupt_controller
  import pic_pkg::*;
#(
  parameter  int NUM_INTERRUPTS = 16,
  parameter  int PRIO_BITS      = 3,
  parameter  int NEST_DEPTH     = 4,
  localparam int ID_W           = $clog2(NUM_INTERRUPTS),
  localparam int LVL_W          = $clog2(NEST_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_INTERRUPTS-1:0] interrupt_pins,
  input  logic                      cfg_we,
  input  logic [ID_W-1:0]           cfg_idx,
  input  logic                      cfg_en,
  input  logic                      cfg_edge,
  input  logic [PRIO_BITS-1:0]      cfg_prio,
  input  logic                      int_ack,
  input  logic                      end_int,
  output logic                      signal_interrupt,
  output logic [ID_W-1:0]           signal_int_id,
  output logic                      in_service,
  output logic [LVL_W-1:0]          nest_level,
  output logic [PRIO_BITS-1:0]      cur_prio,
  output logic [NUM_INTERRUPTS-1:0] pending,
  output logic                      err_underflow
);

  ch_cfg_t                   cfg_q [NUM_INTERRUPTS];
  ch_cfg_t                   cfg_d [NUM_INTERRUPTS];
  logic [NUM_INTERRUPTS-1:0] pin_q;
  logic [NUM_INTERRUPTS-1:0] pend_edge_q, pend_edge_d;
  logic                      sig_q, sig_d;
  int_id_t                   id_q, id_d;
  prio_t                     off_prio_q, off_prio_d;
  stk_entry_t                stk_q [NEST_DEPTH];
  stk_entry_t                stk_d [NEST_DEPTH];
  logic [LVL_W-1:0]          level_q, level_d;
  logic                      err_q, err_d;

  logic [NUM_INTERRUPTS-1:0] in_stack;
  logic [NUM_INTERRUPTS-1:0] pending_w;
  logic [NUM_INTERRUPTS-1:0] elig_w;
  prio_t                     ch_prio [NUM_INTERRUPTS];
  prio_t                     cur_prio_w;
  logic                      stack_full;
  logic                      ack_fire;
  logic                      pop_ok;
  stk_entry_t                new_entry;
  logic                      arb_valid;
  int_id_t                   arb_id;
  prio_t                     arb_prio;
  logic                      unused_bits;

  assign ack_fire   = int_ack & sig_q;
  assign stack_full = (level_q >= LVL_W'(NEST_DEPTH));
  assign new_entry  = '{id: id_q, prio: off_prio_q};

  always_comb begin
    cur_prio_w = '0;
    in_stack   = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (LVL_W'(i + 1) == level_q) cur_prio_w = stk_q[i].prio;
      if (LVL_W'(i) < level_q) begin
        for (int c = 0; c < NUM_INTERRUPTS; c++) begin
          if (stk_q[i].id == int_id_t'(c)) in_stack[c] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_INTERRUPTS; c++) cfg_d[c] = cfg_q[c];
    if (cfg_we && (int'(cfg_idx) < NUM_INTERRUPTS)) begin
      cfg_d[cfg_idx] = '{en: cfg_en, edge_mode: cfg_edge, prio: prio_t'(cfg_prio)};
    end
  end

  // A rising edge on a channel that is already in service is absorbed, not queued.
  always_comb begin
    pend_edge_d = pend_edge_q;
    for (int c = 0; c < NUM_INTERRUPTS; c++) begin
      if (cfg_q[c].edge_mode && interrupt_pins[c] && !pin_q[c] && !in_stack[c]) begin
        pend_edge_d[c] = 1'b1;
      end
      if (ack_fire && (id_q == int_id_t'(c))) pend_edge_d[c] = 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_INTERRUPTS; g++) begin : g_ch
    assign ch_prio[g]   = cfg_q[g].prio;
    assign pending_w[g] = cfg_q[g].edge_mode ? pend_edge_q[g] : pin_q[g];
    assign elig_w[g]    = pending_w[g] & cfg_q[g].en & ~stack_full
                        & prio_above(cfg_q[g].prio, cur_prio_w);
  end

  pic_prio_arbiter #(
    .NUM_CH (NUM_INTERRUPTS)
  ) u_arbiter (
    .eligible  (elig_w),
    .ch_prio   (ch_prio),
    .win_valid (arb_valid),
    .win_id    (arb_id),
    .win_prio  (arb_prio)
  );

  // The offer is frozen from the moment it is registered until the CPU acks it.
  always_comb begin
    sig_d      = sig_q;
    id_d       = id_q;
    off_prio_d = off_prio_q;
    if (ack_fire) begin
      sig_d = 1'b0;
    end else if (!sig_q && arb_valid) begin
      sig_d      = 1'b1;
      id_d       = arb_id;
      off_prio_d = arb_prio;
    end
  end

  always_comb begin
    for (int i = 0; i < NEST_DEPTH; i++) stk_d[i] = stk_q[i];
    level_d = level_q;
    pop_ok  = end_int && (level_q != '0);
    err_d   = end_int && (level_q == '0);
    if (ack_fire && pop_ok) begin
      for (int i = 0; i < NEST_DEPTH; i++) begin
        if (LVL_W'(i + 1) == level_q) stk_d[i] = new_entry;
      end
    end else if (ack_fire) begin
      for (int i = 0; i < NEST_DEPTH; i++) begin
        if (LVL_W'(i) == level_q) stk_d[i] = new_entry;
      end
      level_d = level_q + 1'b1;
    end else if (pop_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_INTERRUPTS; c++) cfg_q[c] <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) stk_q[i] <= '0;
      pin_q       <= '0;
      pend_edge_q <= '0;
      sig_q       <= 1'b0;
      id_q        <= '0;
      off_prio_q  <= '0;
      level_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_INTERRUPTS; c++) cfg_q[c] <= cfg_d[c];
      for (int i = 0; i < NEST_DEPTH; i++) stk_q[i] <= stk_d[i];
      pin_q       <= interrupt_pins;
      pend_edge_q <= pend_edge_d;
      sig_q       <= sig_d;
      id_q        <= id_d;
      off_prio_q  <= off_prio_d;
      level_q     <= level_d;
      err_q       <= err_d;
    end
  end

  assign signal_interrupt = sig_q;
  assign signal_int_id    = id_q[ID_W-1:0];
  assign in_service       = (level_q != '0);
  assign nest_level       = level_q;
  assign cur_prio         = cur_prio_w[PRIO_BITS-1:0];
  assign pending          = pending_w;
  assign err_underflow    = err_q;
  assign unused_bits      = ^{id_q, cur_prio_w};

endmodule

`default_nettype wire

// File: tb/tb_nested_interrupt_controller.sv
// Scoreboard bench for nested_interrupt_controller: expected offer IDs are queued
// when requests are raised and popped when the DUT presents an offer.
`default_nettype none

module tb_nested_interrupt_controller;

  localparam int N  = 16;
  localparam int PB = 3;
  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  interrupt_pins = '0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_idx = '0;
  logic          cfg_en = 1'b0;
  logic          cfg_edge = 1'b0;
  logic [PB-1:0] cfg_prio = '0;
  logic          int_ack = 1'b0;
  logic          end_int = 1'b0;
  logic          signal_interrupt;
  logic [3:0]    signal_int_id;
  logic          in_service;
  logic [2:0]    nest_level;
  logic [PB-1:0] cur_prio;
  logic [N-1:0]  pending;
  logic          err_underflow;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_q[$];

  nested_interrupt_controller #(
    .NUM_INTERRUPTS (N),
    .PRIO_BITS      (PB),
    .NEST_DEPTH     (ND)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .interrupt_pins   (interrupt_pins),
    .cfg_we           (cfg_we),
    .cfg_idx          (cfg_idx),
    .cfg_en           (cfg_en),
    .cfg_edge         (cfg_edge),
    .cfg_prio         (cfg_prio),
    .int_ack          (int_ack),
    .end_int          (end_int),
    .signal_interrupt (signal_interrupt),
    .signal_int_id    (signal_int_id),
    .in_service       (in_service),
    .nest_level       (nest_level),
    .cur_prio         (cur_prio),
    .pending          (pending),
    .err_underflow    (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int idx, input bit en, input bit ed, input int pr);
    cfg_we   = 1'b1;
    cfg_idx  = idx[3:0];
    cfg_en   = en;
    cfg_edge = ed;
    cfg_prio = pr[PB-1:0];
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic pulse(input int ch);
    interrupt_pins[ch] = 1'b1;
    tick();
    interrupt_pins[ch] = 1'b0;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic do_end();
    end_int = 1'b1;
    tick();
    end_int = 1'b0;
  endtask

  task automatic wait_offer(output int cyc);
    cyc = 0;
    while (!signal_interrupt && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({signal_interrupt, signal_int_id, in_service, nest_level, cur_prio, pending, err_underflow} !== '0)
      $display("FAIL reset_outputs: got sig=%0b id=%0d lvl=%0d prio=%0d pend=%h err=%0b, expected all 0",
               signal_interrupt, signal_int_id, nest_level, cur_prio, pending, err_underflow);
    else pass_cnt++;
  endtask

  task automatic test_single_edge();
    int cyc, exp;
    for (int c = 0; c < N; c++) set_cfg(c, 1'b1, 1'b1, 1);
    pulse(5);
    exp_q.push_back(5);
    wait_offer(cyc);
    exp = exp_q.pop_front();
    total_cnt++;
    if (signal_interrupt !== 1'b1 || int'(signal_int_id) !== exp || cyc + 1 !== 2)
      $display("FAIL single_offer: got sig=%0b id=%0d latency=%0d, expected id=%0d latency=2",
               signal_interrupt, signal_int_id, cyc + 1, exp);
    else pass_cnt++;
    do_ack();
    total_cnt++;
    if (pending[5] !== 1'b0 || nest_level !== 3'd1 || cur_prio !== 3'd1 || signal_interrupt !== 1'b0)
      $display("FAIL single_ack: got pend5=%0b lvl=%0d prio=%0d sig=%0b, expected 0/1/1/0",
               pending[5], nest_level, cur_prio, signal_interrupt);
    else pass_cnt++;
    do_end();
    total_cnt++;
    if (in_service !== 1'b0 || nest_level !== 3'd0)
      $display("FAIL single_end: got in_service=%0b lvl=%0d, expected 0/0", in_service, nest_level);
    else pass_cnt++;
  endtask

  task automatic test_tie_break();
    int cyc, exp;
    set_cfg(3, 1'b1, 1'b1, 2);
    set_cfg(9, 1'b1, 1'b1, 2);
    interrupt_pins[3] = 1'b1;
    interrupt_pins[9] = 1'b1;
    tick();
    interrupt_pins[3] = 1'b0;
    interrupt_pins[9] = 1'b0;
    exp_q.push_back(9);
    exp_q.push_back(3);
    wait_offer(cyc);
    exp = exp_q.pop_front();
    total_cnt++;
    if (signal_interrupt !== 1'b1 || int'(signal_int_id) !== exp)
      $display("FAIL tie_first: got sig=%0b id=%0d, expected id=%0d", signal_interrupt, signal_int_id, exp);
    else pass_cnt++;
    do_ack();
    repeat (3) tick();
    total_cnt++;
    if (signal_interrupt !== 1'b0 || pending[3] !== 1'b1)
      $display("FAIL tie_hold: got sig=%0b pend3=%0b, expected sig=0 pend3=1", signal_interrupt, pending[3]);
    else pass_cnt++;
    do_end();
    wait_offer(cyc);
    exp = exp_q.pop_front();
    total_cnt++;
    if (signal_interrupt !== 1'b1 || int'(signal_int_id) !== exp)
      $display("FAIL tie_second: got sig=%0b id=%0d, expected id=%0d", signal_interrupt, signal_int_id, exp);
    else pass_cnt++;
    do_ack();
    do_end();
  endtask

  task automatic test_preempt();
    int cyc, exp;
    set_cfg(2, 1'b1, 1'b1, 1);
    set_cfg(7, 1'b1, 1'b1, 4);
    pulse(2);
    exp_q.push_back(2);
    wait_offer(cyc);
    exp = exp_q.pop_front();
    total_cnt++;
    if (int'(signal_int_id) !== exp || signal_interrupt !== 1'b1)
      $display("FAIL preempt_low: got sig=%0b id=%0d, expected id=%0d", signal_interrupt, signal_int_id, exp);
    else pass_cnt++;
    do_ack();
    pulse(7);
    exp_q.push_back(7);
    wait_offer(cyc);
    exp = exp_q.pop_front();
    total_cnt++;
    if (int'(signal_int_id) !== exp || signal_interrupt !== 1'b1 || in_service !== 1'b1)
      $display("FAIL preempt_offer: got sig=%0b id=%0d in_service=%0b, expected id=%0d in_service=1",
               signal_interrupt, signal_int_id, in_service, exp);
    else pass_cnt++;
    do_ack();
    total_cnt++;
    if (nest_level !== 3'd2 || cur_prio !== 3'd4)
      $display("FAIL preempt_nest: got lvl=%0d prio=%0d, expected 2/4", nest_level, cur_prio);
    else pass_cnt++;
    do_end();
    total_cnt++;
    if (cur_prio !== 3'd1 || nest_level !== 3'd1)
      $display("FAIL preempt_pop1: got lvl=%0d prio=%0d, expected 1/1", nest_level, cur_prio);
    else pass_cnt++;
    do_end();
    total_cnt++;
    if (in_service !== 1'b0 || cur_prio !== 3'd0)
      $display("FAIL preempt_pop2: got in_service=%0b prio=%0d, expected 0/0", in_service, cur_prio);
    else pass_cnt++;
  endtask

  task automatic test_equal_prio();
    int cyc, exp;
    bit seen;
    set_cfg(4, 1'b1, 1'b1, 3);
    set_cfg(6, 1'b1, 1'b1, 3);
    pulse(4);
    exp_q.push_back(4);
    wait_offer(cyc);
    exp = exp_q.pop_front();
    total_cnt++;
    if (int'(signal_int_id) !== exp || signal_interrupt !== 1'b1)
      $display("FAIL equal_first: got sig=%0b id=%0d, expected id=%0d", signal_interrupt, signal_int_id, exp);
    else pass_cnt++;
    do_ack();
    pulse(6);
    exp_q.push_back(6);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (signal_interrupt) seen = 1'b1;
    end
    do_ack();
    total_cnt++;
    if (seen !== 1'b0 || nest_level !== 3'd1)
      $display("FAIL equal_no_preempt: got offer_seen=%0b lvl=%0d, expected 0/1", seen, nest_level);
    else pass_cnt++;
    do_end();
    wait_offer(cyc);
    exp = exp_q.pop_front();
    total_cnt++;
    if (int'(signal_int_id) !== exp || signal_interrupt !== 1'b1)
      $display("FAIL equal_after_end: got sig=%0b id=%0d, expected id=%0d", signal_interrupt, signal_int_id, exp);
    else pass_cnt++;
    do_ack();
    do_end();
  endtask

  task automatic test_depth_underflow();
    int cyc, exp;
    bit seen;
    for (int k = 0; k < 5; k++) set_cfg(10 + k, 1'b1, 1'b1, k + 1);
    for (int k = 0; k < 4; k++) begin
      pulse(10 + k);
      exp_q.push_back(10 + k);
      wait_offer(cyc);
      exp = exp_q.pop_front();
      total_cnt++;
      if (int'(signal_int_id) !== exp || signal_interrupt !== 1'b1)
        $display("FAIL chain_offer%0d: got sig=%0b id=%0d, expected id=%0d",
                 k, signal_interrupt, signal_int_id, exp);
      else pass_cnt++;
      do_ack();
    end
    pulse(14);
    exp_q.push_back(14);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (signal_interrupt) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0 || nest_level !== 3'd4 || pending[14] !== 1'b1)
      $display("FAIL depth_full: got offer_seen=%0b lvl=%0d pend14=%0b, expected 0/4/1",
               seen, nest_level, pending[14]);
    else pass_cnt++;
    do_end();
    wait_offer(cyc);
    exp = exp_q.pop_front();
    total_cnt++;
    if (int'(signal_int_id) !== exp || signal_interrupt !== 1'b1 || cur_prio !== 3'd3)
      $display("FAIL depth_release: got sig=%0b id=%0d prio=%0d, expected id=%0d prio=3",
               signal_interrupt, signal_int_id, cur_prio, exp);
    else pass_cnt++;
    do_ack();
    repeat (4) do_end();
    total_cnt++;
    if (nest_level !== 3'd0 || err_underflow !== 1'b0)
      $display("FAIL depth_drain: got lvl=%0d err=%0b, expected 0/0", nest_level, err_underflow);
    else pass_cnt++;
    do_end();
    total_cnt++;
    if (err_underflow !== 1'b1 || nest_level !== 3'd0)
      $display("FAIL underflow_pulse: got err=%0b lvl=%0d, expected 1/0", err_underflow, nest_level);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (err_underflow !== 1'b0)
      $display("FAIL underflow_width: got err=%0b, expected 0", err_underflow);
    else pass_cnt++;
  endtask

  task automatic test_level_and_reset();
    int cyc, exp;
    set_cfg(1, 1'b1, 1'b0, 2);
    interrupt_pins[1] = 1'b1;
    exp_q.push_back(1);
    wait_offer(cyc);
    exp = exp_q.pop_front();
    total_cnt++;
    if (int'(signal_int_id) !== exp || signal_interrupt !== 1'b1)
      $display("FAIL level_offer: got sig=%0b id=%0d, expected id=%0d", signal_interrupt, signal_int_id, exp);
    else pass_cnt++;
    do_ack();
    repeat (3) tick();
    total_cnt++;
    if (signal_interrupt !== 1'b0 || pending[1] !== 1'b1 || nest_level !== 3'd1)
      $display("FAIL level_held: got sig=%0b pend1=%0b lvl=%0d, expected 0/1/1",
               signal_interrupt, pending[1], nest_level);
    else pass_cnt++;
    exp_q.push_back(1);
    do_end();
    wait_offer(cyc);
    exp = exp_q.pop_front();
    total_cnt++;
    if (int'(signal_int_id) !== exp || signal_interrupt !== 1'b1)
      $display("FAIL level_reoffer: got sig=%0b id=%0d, expected id=%0d", signal_interrupt, signal_int_id, exp);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({signal_interrupt, signal_int_id, in_service, nest_level, cur_prio, pending, err_underflow} !== '0)
      $display("FAIL async_reset: got sig=%0b id=%0d lvl=%0d prio=%0d pend=%h err=%0b, expected all 0",
               signal_interrupt, signal_int_id, nest_level, cur_prio, pending, err_underflow);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if (signal_interrupt !== 1'b0)
      $display("FAIL reset_cfg_cleared: got sig=%0b, expected 0", signal_interrupt);
    else pass_cnt++;
    interrupt_pins = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_single_edge();
    test_tie_break();
    test_preempt();
    test_equal_prio();
    test_depth_underflow();
    test_level_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
